// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit adder built from one shared 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Define SUB_EN to add a sub port that turns the operation into a-b.
module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [NIB-1:0][3:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           an, bn, p, g, c, s_n;
  logic                 grp_g, grp_p, c_out, sub_i;
`ifdef SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign an    = a_q[idx_q];
  assign bn    = b_q[idx_q];
  assign p     = an ^ bn;
  assign g     = an & bn;
  assign c     = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & carry_q,
                  g[1] | p[1] & g[0] | p[1] & p[0] & carry_q,
                  g[0] | p[0] & carry_q,
                  carry_q};
  assign grp_g = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
  assign grp_p = &p;
  assign c_out = grp_g | grp_p & carry_q;
  assign s_n   = p ^ c;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = carry_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = sub_i ? ~b : b;
      carry_d = sub_i | cin;
      idx_d   = '0;
      sum_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[idx_q] = s_n;
      carry_d      = c_out;
      state_d      = idx_q == IW'(NIB - 1) ? DONE : RUN;
      idx_d        = idx_q == IW'(NIB - 1) ? idx_q : idx_q + 1'b1;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb_cla_nibble_seq: table-driven vectors plus hand sequences for backpressure, mid-run reset and back-to-back accepts.
module tb_cla_nibble_seq;
  localparam int W = 16;
  localparam int NIB = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
  typedef struct {logic [15:0] a; logic [15:0] b; logic ci; logic [15:0] s; logic co;} vec_t;
  typedef struct {logic [15:0] s; logic co;} exp_t;
  vec_t tbl[9];
  exp_t sb_q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
  logic ov_prev = 0;

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic ci, input logic sb,
                      input logic [15:0] es, input logic eco);
    int t = 0;
    while (!in_ready && t < 100) begin tick(); t++; end
    chk("send_wait_ready", in_ready, 1);
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1;
    @(posedge clk);
    sb_q.push_back('{es, eco});
    #1 acc_cyc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb_q.size() != 0 || !in_ready) && t < 200) begin tick(); t++; end
    chk("drain_queue_empty", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    chk("ready_valid_exclusive", in_ready && out_valid, 0);
    chk("busy_vs_ready", busy, !in_ready);
    if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, NIB);
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.co);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, last;
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    tbl[8] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, tbl[i].s, tbl[i].co);
    wait_drain();
    out_ready = 0;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    chk("bp_out_valid_rise", out_valid, 1);
    a = 16'h5555; b = 16'h2222; in_valid = 1;
    repeat (6) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_sum", sum, 16'h0000);
      chk("bp_hold_cout", cout, 1);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    a = 16'h1234; b = 16'h4321; cin = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("mr_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_sum", sum, 0);
    chk("mr_cout", cout, 0);
    tick();
    rst_n = 1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    wait_drain();
`ifdef SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
    wait_drain();
`endif
    in_valid = 1; sub = 0; cin = 0; last = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!in_ready && t < 50) begin tick(); t++; end
      chk("b2b_ready", in_ready, 1);
      a = 16'h1000 * (k + 1); b = 16'h0111;
      @(posedge clk);
      sb_q.push_back('{a + b, 1'b0});
      #1 acc_cyc = cyc;
      if (k > 0) chk("b2b_gap", cyc - last, NIB + 2);
      last = cyc;
    end
    in_valid = 0;
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
